// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding AXI4 initiator. Turns one read or write
// INCR-burst command plus local data streams into AXI4 traffic.
module axi_cmd_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      done,
  output logic [1:0]                done_resp,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [2:0]          AXSIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ID_WIDTH-1:0] ID     = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [1:0]              resp_q, resp_d;
  logic                    done_q, done_d;
  logic [1:0]              done_resp_q, done_resp_d;

  logic                    r_beat_last;
  logic                    r_beat_err;
  logic [1:0]              r_resp_max;

  assign m_axi_awid    = ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot  = '0;
  assign m_axi_arid    = ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = m_axi_rlast;
  assign done          = done_q;
  assign done_resp     = done_resp_q;

  // Read-beat bookkeeping: a beat is "last" either by rlast or by reaching len;
  // any disagreement between the two, or a foreign rid, is a protocol error.
  assign r_beat_last = (cnt_q == len_q);
  assign r_beat_err  = (m_axi_rlast != r_beat_last) || (m_axi_rid != ID);
  assign r_resp_max  = (m_axi_rresp > resp_q) ? m_axi_rresp : resp_q;

  // State and datapath registers; reset abandons any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      resp_q      <= '0;
      done_q      <= 1'b0;
      done_resp_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      resp_q      <= resp_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

  // Next-state and handshake outputs for the one-transaction-at-a-time FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    resp_d        = resp_q;
    done_d        = 1'b0;
    done_resp_d   = done_resp_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          resp_d  = '0;
          state_d = cmd_write ? AW : AR;
        end
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = W;
      end
      W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = (cnt_q == len_q);
        if (wr_valid && m_axi_wready) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = B;
        end
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          done_resp_d = (m_axi_bid != ID) ? 2'b10 : m_axi_bresp;
        end
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = R;
      end
      R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        if (m_axi_rvalid && rd_ready) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          resp_d = r_resp_max;
          err_d  = err_q | r_beat_err;
          if (m_axi_rlast || r_beat_last) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            done_resp_d = (err_q | r_beat_err) ? 2'b10 : r_resp_max;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed testbench for axi_cmd_master acting as its own AXI responder.
module tb_axi_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [3:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_cmd_master #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .ID_WIDTH(4), .AXI_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  // Full write transaction with optional AW delay, a one-cycle wready stall, and B response.
  task automatic run_write(input logic [63:0] addr, input logic [7:0] len, input int aw_delay,
                           input int stall_beat, input logic [3:0] b_id, input logic [1:0] b_resp,
                           input logic [1:0] exp_resp, input string nm);
    int beats = 0;
    int cyc = 0;
    int hs_count = 0;
    logic stalled = 0;
    logic hs;
    logic [63:0] exp_data;
    cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
    wr_valid = 1; wready = 1; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb = 8'hFF;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready got=%b exp=1", nm, cmd_ready); end
    tick();
    cmd_valid = 0;
    for (int i = 0; i <= aw_delay; i++) begin
      if (i == aw_delay) awready = 1;
      #1;
      checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL %s awvalid got=%b exp=1", nm, awvalid); end
      checks++; if (awaddr !== addr) begin errors++; $display("FAIL %s awaddr got=%h exp=%h", nm, awaddr, addr); end
      checks++; if (awlen !== len) begin errors++; $display("FAIL %s awlen got=%h exp=%h", nm, awlen, len); end
      checks++; if ({awid, awsize, awburst} !== {4'd0, 3'd3, 2'b01}) begin errors++; $display("FAIL %s aw id/size/burst got=%h/%h/%h exp=0/3/1", nm, awid, awsize, awburst); end
      checks++; if ({wvalid, wr_ready} !== 2'b00) begin errors++; $display("FAIL %s early W got wvalid=%b wr_ready=%b exp=0/0", nm, wvalid, wr_ready); end
      tick();
    end
    awready = 0;
    while (beats <= int'(len) && cyc < 600) begin
      exp_data = 64'hA5A5_0000_0000_0000 | 64'(beats);
      wr_data = exp_data;
      wr_strb = 8'hFF ^ 8'(beats);
      wready = 1;
      if (beats == stall_beat && !stalled) begin wready = 0; stalled = 1; end
      #1;
      checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL %s awvalid in W got=%b exp=0", nm, awvalid); end
      checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL %s wvalid beat %0d got=%b exp=1", nm, beats, wvalid); end
      checks++; if (wdata !== exp_data || wstrb !== (8'hFF ^ 8'(beats))) begin errors++; $display("FAIL %s wdata/wstrb beat %0d got=%h/%h exp=%h/%h", nm, beats, wdata, wstrb, exp_data, 8'hFF ^ 8'(beats)); end
      checks++; if (wlast !== (beats == int'(len))) begin errors++; $display("FAIL %s wlast beat %0d got=%b exp=%b", nm, beats, wlast, beats == int'(len)); end
      checks++; if (wr_ready !== wready) begin errors++; $display("FAIL %s wr_ready got=%b exp=%b", nm, wr_ready, wready); end
      hs = wready;
      tick();
      if (hs) begin beats++; hs_count++; end
      cyc++;
    end
    wready = 0;
    checks++; if (hs_count !== int'(len) + 1) begin errors++; $display("FAIL %s W handshakes got=%0d exp=%0d (timeout)", nm, hs_count, int'(len) + 1); end
    checks++; if ({bready, wvalid} !== 2'b10) begin errors++; $display("FAIL %s B phase got bready=%b wvalid=%b exp=1/0", nm, bready, wvalid); end
    bvalid = 1; bid = b_id; bresp = b_resp;
    tick();
    bvalid = 0; bid = '0; bresp = '0; wr_valid = 0;
    checks++; if (done !== 1'b1 || done_resp !== exp_resp) begin errors++; $display("FAIL %s done/resp got=%b/%b exp=1/%b", nm, done, done_resp, exp_resp); end
    checks++; if ({cmd_ready, bready} !== 2'b10) begin errors++; $display("FAIL %s after B got cmd_ready=%b bready=%b exp=1/0", nm, cmd_ready, bready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done pulse width got=%b exp=0", nm, done); end
  endtask

  // Full read transaction; responder raises rlast at last_idx (-1: never) and rresp at bad_idx.
  task automatic run_read(input logic [63:0] addr, input logic [7:0] len, input int last_idx,
                          input int bad_idx, input logic [1:0] bad_resp, input logic toggle,
                          input int exp_beats, input logic [1:0] exp_resp, input string nm);
    int beats = 0;
    int cyc = 0;
    logic hs;
    logic [63:0] exp_data;
    cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready got=%b exp=1", nm, cmd_ready); end
    tick();
    cmd_valid = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== addr || arlen !== len) begin errors++; $display("FAIL %s AR got v=%b addr=%h len=%h exp 1/%h/%h", nm, arvalid, araddr, arlen, addr, len); end
    checks++; if ({arid, arsize, arburst, awvalid} !== {4'd0, 3'd3, 2'b01, 1'b0}) begin errors++; $display("FAIL %s ar id/size/burst got=%h/%h/%h exp=0/3/1", nm, arid, arsize, arburst); end
    arready = 1;
    tick();
    arready = 0;
    while (beats < exp_beats && cyc < 600) begin
      exp_data = 64'hD000_0000_0000_0000 | 64'(beats);
      rvalid = 1; rid = '0; rdata = exp_data;
      rresp = (beats == bad_idx) ? bad_resp : 2'b00;
      rlast = (beats == last_idx);
      rd_ready = toggle ? cyc[0] : 1'b1;
      #1;
      checks++; if (arvalid !== 1'b0 || rd_valid !== 1'b1) begin errors++; $display("FAIL %s rd_valid beat %0d got=%b arvalid=%b exp=1/0", nm, beats, rd_valid, arvalid); end
      checks++; if (rd_data !== exp_data || rd_last !== (beats == last_idx)) begin errors++; $display("FAIL %s rd beat %0d got=%h/%b exp=%h/%b", nm, beats, rd_data, rd_last, exp_data, beats == last_idx); end
      checks++; if (rready !== rd_ready) begin errors++; $display("FAIL %s rready got=%b exp=%b", nm, rready, rd_ready); end
      hs = rd_ready;
      tick();
      if (hs) beats++;
      cyc++;
    end
    rvalid = 0; rlast = 0; rresp = '0; rd_ready = 1;
    checks++; if (beats !== exp_beats) begin errors++; $display("FAIL %s beats got=%0d exp=%0d (timeout)", nm, beats, exp_beats); end
    #1;
    checks++; if (done !== 1'b1 || done_resp !== exp_resp) begin errors++; $display("FAIL %s done/resp got=%b/%b exp=1/%b", nm, done, done_resp, exp_resp); end
    checks++; if ({cmd_ready, rready} !== 2'b10) begin errors++; $display("FAIL %s after R got cmd_ready=%b rready=%b exp=1/0", nm, cmd_ready, rready); end
    rd_ready = 0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done pulse width got=%b exp=0", nm, done); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    wr_valid = 1; wready = 1; rvalid = 1; rd_ready = 1; bvalid = 1;
    #2;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin errors++; $display("FAIL reset valids got=%b exp=000", {awvalid, wvalid, arvalid}); end
    checks++; if ({bready, rready, wr_ready, rd_valid} !== 4'b0000) begin errors++; $display("FAIL reset readies got=%b exp=0000", {bready, rready, wr_ready, rd_valid}); end
    checks++; if (done !== 1'b0 || done_resp !== 2'b00) begin errors++; $display("FAIL reset done got=%b/%b exp=0/00", done, done_resp); end
    tick();
    idle_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_write();
    run_write(64'h1_0000, 8'd0, 0, -1, 4'd0, 2'b00, 2'b00, "single_write");
  endtask

  task automatic test_read_toggle();
    run_read(64'h1_00A0, 8'd3, 3, -1, 2'b00, 1'b1, 4, 2'b00, "read4_toggle");
  endtask

  task automatic test_write_backpressure();
    run_write(64'h2_0040, 8'd3, 5, 2, 4'd0, 2'b00, 2'b00, "write_bp");
  endtask

  task automatic test_error_resp();
    run_read(64'h3_0000, 8'd1, 1, 1, 2'b10, 1'b0, 2, 2'b10, "read_slverr");
    run_read(64'h3_0100, 8'd2, 2, 0, 2'b01, 1'b0, 3, 2'b01, "read_exokay");
    run_write(64'h3_0200, 8'd1, 1, -1, 4'd0, 2'b11, 2'b11, "write_decerr");
    run_write(64'h3_0300, 8'd0, 0, -1, 4'd5, 2'b00, 2'b10, "write_bad_bid");
  endtask

  task automatic test_protocol_error();
    run_read(64'h4_0000, 8'd3, 1, -1, 2'b00, 1'b0, 2, 2'b10, "early_rlast");
    run_read(64'h4_0100, 8'd1, -1, -1, 2'b00, 1'b0, 2, 2'b10, "missing_rlast");
  endtask

  task automatic test_back_to_back();
    run_read(64'h5_0000, 8'd0, 0, -1, 2'b00, 1'b0, 1, 2'b00, "b2b_read");
    run_write(64'h5_0100, 8'd15, 0, 7, 4'd0, 2'b00, 2'b00, "b2b_write16");
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 64'h6_0000; cmd_len = 8'd7;
    tick();
    cmd_valid = 0; awready = 1;
    tick();
    awready = 0; wr_valid = 1; wready = 1;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++; if ({wvalid, awvalid, bready, wr_ready} !== 4'b0000) begin errors++; $display("FAIL mid_reset outputs got=%b exp=0000", {wvalid, awvalid, bready, wr_ready}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset cmd_ready got=%b exp=1", cmd_ready); end
    tick();
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset idle cyc %0d got done=%b cmd_ready=%b exp=0/1", i, done, cmd_ready); end
      tick();
    end
    run_read(64'h6_0100, 8'd0, 0, -1, 2'b00, 1'b0, 1, 2'b00, "post_reset_read");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_toggle();
    test_write_backpressure();
    test_error_resp();
    test_protocol_error();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
